// File: rtl/char_grid_display.sv
// Character-cell display: ROWS x COLS digit glyphs with colour/inverse attributes from a single-port RAM.
// Host writes and the clear/fill engine only touch the RAM while display_on is low.
module char_grid_display #(
  parameter int COLS_LOG2   = 5,
  parameter int ROWS_LOG2   = 5,
  parameter int SCALE_SHIFT = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [9:0]                     hpos,
  input  logic [9:0]                     vpos,
  input  logic                           display_on,
  input  logic                           hsync_in,
  input  logic                           vsync_in,
  output logic                           hsync,
  output logic                           vsync,
  output logic [2:0]                     rgb,
  input  logic                           host_valid,
  output logic                           host_ready,
  input  logic [COLS_LOG2+ROWS_LOG2-1:0] host_addr,
  input  logic [7:0]                     host_data,
  input  logic                           clear_req,
  input  logic [7:0]                     fill_data,
  output logic                           clear_busy
);
  localparam int AW = COLS_LOG2 + ROWS_LOG2;
  localparam int CS = 3 + SCALE_SHIFT;

  typedef enum logic [0:0] {IDLE, CLEAR} state_t;
  state_t state;

  logic [AW-1:0] cnt;
  logic [7:0]    fill;

  // cell decode
  logic [9:0]    row, col;
  logic [2:0]    gx, gy;
  logic          oog;
  logic [AW-1:0] vid_addr;

  assign row      = vpos >> CS;
  assign col      = hpos >> CS;
  assign gx       = hpos[SCALE_SHIFT +: 3];
  assign gy       = vpos[SCALE_SHIFT +: 3];
  assign oog      = ((row >> ROWS_LOG2) != '0) || ((col >> COLS_LOG2) != '0);
  assign vid_addr = {row[ROWS_LOG2-1:0], col[COLS_LOG2-1:0]};

  // RAM port arbitration: video owns it in active area, clear engine beats host in blanking
  logic          clr_we, host_we, ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata, rd_word;

  assign host_ready = reset && !display_on && (state == IDLE);
  assign host_we    = host_valid && host_ready;
  assign clr_we     = (state == CLEAR) && !display_on;
  assign ram_we     = clr_we || host_we;
  assign ram_addr   = display_on ? vid_addr : (clr_we ? cnt : host_addr);
  assign ram_wdata  = clr_we ? fill : host_data;

  logic [7:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rd_word <= mem[ram_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      fill       <= '0;
      clear_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (clear_req) begin
          state      <= CLEAR;
          fill       <= fill_data;
          cnt        <= '0;
          clear_busy <= 1'b1;
        end
        CLEAR: if (!display_on) begin
          cnt <= cnt + 1'b1;
          if (cnt == {AW{1'b1}}) begin
            state      <= IDLE;
            clear_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // 5x5 digit glyphs, MSB is the leftmost pixel; rows 5..7 and codes 10..15 are blank
  function automatic logic [4:0] glyph_row(input logic [3:0] code, input logic [2:0] y);
    logic [24:0] g;
    g = '0;
    case (code)
      4'd0: g = 25'b11111_10001_10001_10001_11111;
      4'd1: g = 25'b01100_00100_00100_00100_11111;
      4'd2: g = 25'b11111_00001_11111_10000_11111;
      4'd3: g = 25'b11111_00001_11111_00001_11111;
      4'd4: g = 25'b10001_10001_11111_00001_00001;
      4'd5: g = 25'b11111_10000_11111_00001_11111;
      4'd6: g = 25'b11111_10000_11111_10001_11111;
      4'd7: g = 25'b11111_00001_00001_00001_00001;
      4'd8: g = 25'b11111_10001_11111_10001_11111;
      4'd9: g = 25'b11111_10001_11111_00001_11111;
      default: g = '0;
    endcase
    glyph_row = (y < 3'd5) ? g[(4 - int'(y)) * 5 +: 5] : 5'b0;
  endfunction

  logic [2:0] gx_d, gy_d;
  logic       don_d, oog_d, hs_d, vs_d;
  logic [4:0] rom_bits;
  logic       gbit, pix_on;

  assign rom_bits = glyph_row(rd_word[3:0], gy_d);
  assign gbit     = (gx_d < 3'd5) ? rom_bits[4 - int'(gx_d)] : 1'b0;
  assign pix_on   = gbit ^ rd_word[7];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gx_d  <= '0;
      gy_d  <= '0;
      don_d <= 1'b0;
      oog_d <= 1'b0;
      hs_d  <= 1'b0;
      vs_d  <= 1'b0;
      rgb   <= '0;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else begin
      gx_d  <= gx;
      gy_d  <= gy;
      don_d <= display_on;
      oog_d <= oog;
      hs_d  <= hsync_in;
      vs_d  <= vsync_in;
      rgb   <= (don_d && !oog_d && pix_on) ? rd_word[6:4] : 3'b000;
      hsync <= hs_d;
      vsync <= vs_d;
    end
  end
endmodule
